// File: rtl/fetch_seq.sv
// Instruction fetch/next-PC sequencer: fetches a word, waits for the datapath
// to finish it, then selects the next PC or traps on a misaligned target.
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic        instr_valid,
  input  logic        exec_done,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [25:0] imm26,
  input  logic [31:0] addr32,
  input  logic        stall,
  output logic [31:0] pc,
  output logic        trap,
  output logic [31:0] retired
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC, TRAP} state_t;

  localparam logic [1:0] OP_PLUS4  = 2'b00;
  localparam logic [1:0] OP_BRANCH = 2'b01;
  localparam logic [1:0] OP_JIMM   = 2'b10;

  state_t      state;
  logic [31:0] pc_plus4;
  logic [31:0] br_offset;
  logic [31:0] next_pc;

  assign imem_req  = (state == FETCH);
  assign imem_addr = pc;
  assign pc_plus4  = pc + 32'd4;
  assign br_offset = {{14{imm26[15]}}, imm26[15:0], 2'b00};

  // NOTE: next_pc gets a value on every path (default first), so no latch is inferred.
  always_comb begin
    next_pc = addr32;
    case (npc_op)
      OP_PLUS4:  next_pc = pc_plus4;
      OP_BRANCH: next_pc = br_taken ? pc_plus4 + br_offset : pc_plus4;
      OP_JIMM:   next_pc = {pc_plus4[31:28], imm26, 2'b00};
      default:   next_pc = addr32;
    endcase
  end

  // NOTE: all state updates use non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_valid <= 1'b0;
      trap        <= 1'b0;
      retired     <= 32'h0;
    end else begin
      instr_valid <= 1'b0;
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            instr_valid <= 1'b1;
            state       <= EXEC;
          end
        end
        EXEC: begin
          if (exec_done && !stall) begin
            if (next_pc[1:0] != 2'b00) begin
              trap  <= 1'b1;
              state <= TRAP;
            end else begin
              pc      <= next_pc;
              retired <= retired + 32'd1;
              state   <= FETCH;
            end
          end
        end
        TRAP:    state <= TRAP;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fetch_seq.md
FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port imem_req  output  1  instruction-memory read request.
REQ-005 SHALL have port imem_addr  output  32  fetch address, equal to pc.
REQ-006 SHALL have port imem_ack  input  1  memory ack; imem_rdata valid in the same cycle.
REQ-007 SHALL have port imem_rdata  input  32  fetched instruction word.
REQ-008 SHALL have port instr  output  32  latched current instruction.
REQ-009 SHALL have port instr_valid  output  1  one-cycle pulse when instr is newly latched.
REQ-010 SHALL have port exec_done  input  1  datapath finished current instruction; npc_op, br_taken, imm26 and addr32 are valid this cycle.
REQ-011 SHALL have port npc_op  input  2  next-PC select: 00 plus4, 01 branch, 10 jump-imm, 11 jump-reg.
REQ-012 SHALL have port br_taken  input  1  branch condition result.
REQ-013 SHALL have port imm26  input  26  immediate field.
REQ-014 SHALL have port addr32  input  32  register jump target.
REQ-015 SHALL have port stall  input  1  hold PC update.
REQ-016 SHALL have port pc  output  32  current program counter.
REQ-017 SHALL have port trap  output  1  misaligned-target fault, sticky.
REQ-018 SHALL have port retired  output  32  count of retired instructions.

Function
REQ-019 SHALL implement states IDLE, FETCH, EXEC, TRAP, all registered on clk.
REQ-020 SHALL move IDLE->FETCH unconditionally on the next clock edge.
REQ-021 SHALL drive imem_req=1 combinationally only in FETCH; imem_addr=pc at all times.
REQ-022 SHALL, in FETCH with imem_ack=1, latch imem_rdata into instr, pulse instr_valid for the following cycle only, and go to EXEC; with imem_ack=0, hold in FETCH.
REQ-023 SHALL, in EXEC, ignore imem_ack and wait for exec_done=1.
REQ-024 SHALL, in EXEC with exec_done=1 and stall=1, stay in EXEC with pc unchanged; exec_done is re-sampled on the next cycle.
REQ-025 SHALL, in EXEC with exec_done=1 and stall=0, compute next PC: plus4 = pc+4; branch = pc+4+{sign-extended imm26[15:0],2'b00} when br_taken=1, else pc+4; jump-imm = {(pc+4)[31:28],imm26,2'b00}; jump-reg = addr32.
REQ-026 SHALL perform all next-PC arithmetic modulo 2^32; wrap-around is not a fault.
REQ-027 SHALL, when the next PC has bits [1:0]!=0 (jump-reg only), leave pc unchanged, set trap=1, and go to TRAP; otherwise load pc with the next PC, increment retired by 1 (wrap at 2^32), and go to FETCH.
REQ-028 SHALL hold TRAP indefinitely, with imem_req=0 and all outputs frozen, until rst.
REQ-029 SHALL not increment retired for a trapping instruction.

Reset
REQ-030 SHALL, while rst=1, force state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, trap=0, retired=0, imem_req=0, independent of clk.
REQ-031 SHALL, on rst assertion during FETCH or EXEC, abandon the operation; a late imem_ack after reset is ignored unless the block is in FETCH.

Verification
REQ-032 Reset then ack on the 3rd FETCH cycle with rdata=32'h2008_0005 -> imem_addr=0, instr=32'h2008_0005, instr_valid high for exactly 1 cycle.
REQ-033 pc=0x100, npc_op=01, imm26[15:0]=16'hFFFF, br_taken=1, exec_done -> pc=0x100; with br_taken=0 -> pc=0x104.
REQ-034 pc=0x3000_0010, npc_op=10, imm26=26'h000_0040 -> pc=0x3000_0100, retired incremented by 1.
REQ-035 npc_op=11, addr32=0x0000_0042 -> trap=1, pc unchanged, imem_req=0 thereafter, retired unchanged.
REQ-036 exec_done=1 with stall=1 for 3 cycles, then stall=0 -> pc updates only after stall drops; exactly one increment of retired.
REQ-037 rst asserted mid-FETCH with imem_req=1 -> imem_req drops immediately, pc=RESET_PC, IDLE then FETCH after release.
